// File: rtl/vga_attr_pkg.sv
// Shared widths, RGB type and the fixed 16-entry CGA palette
// for the VGA text attribute decoder.
package vga_attr_pkg;

  localparam int RGB_W = 12;
  localparam int IDX_W = 4;
  localparam int PAL_N = 16;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Entry 6 is brown (A50), not the dark yellow (AA0) of the raw formula.
  localparam rgb_t PALETTE [PAL_N] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  function automatic rgb_t pal_lookup(input idx_t idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_palette_lut.sv
// Combinational 4-bit palette index to 12-bit RGB lookup.
// One instance each for the foreground and background paths.
module vga_palette_lut
  import vga_attr_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [RGB_W-1:0] rgb_o
);

  always_comb begin
    rgb_o = pal_lookup(idx_i);
  end

endmodule

// File: rtl/vga_attribute_decoder.sv
// Attribute byte to registered fg/bg RGB colours, one-cycle latency.
// Define VGA_ATTR_BLINK_EN to treat attr[7] as blink instead of bright bg.
module vga_attribute_decoder
  import vga_attr_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [7:0]       attr_i,
  input  logic             blink_i,
  output logic [RGB_W-1:0] fg_rgb_o,
  output logic [RGB_W-1:0] bg_rgb_o
);

  idx_t fg_idx;
  idx_t bg_idx;
  rgb_t fg_lut;
  rgb_t bg_lut;
  rgb_t fg_sel;
  logic hide;

  rgb_t fg_rgb_d;
  rgb_t fg_rgb_q;
  rgb_t bg_rgb_d;
  rgb_t bg_rgb_q;

  always_comb begin
    fg_idx = attr_i[3:0];
`ifdef VGA_ATTR_BLINK_EN
    bg_idx = {1'b0, attr_i[6:4]};
    hide   = attr_i[7] & blink_i;
`else
    bg_idx = attr_i[7:4];
    hide   = 1'b0;
`endif
  end

`ifndef VGA_ATTR_BLINK_EN
  logic unused_blink;
  assign unused_blink = blink_i;
`endif

  vga_palette_lut u_fg_lut (
    .idx_i (fg_idx),
    .rgb_o (fg_lut)
  );

  vga_palette_lut u_bg_lut (
    .idx_i (bg_idx),
    .rgb_o (bg_lut)
  );

  // A hidden glyph is drawn in the cell's own background colour.
  always_comb begin
    fg_sel   = hide ? bg_lut : fg_lut;
    fg_rgb_d = fg_rgb_q;
    bg_rgb_d = bg_rgb_q;
    if (en_i) begin
      fg_rgb_d = fg_sel;
      bg_rgb_d = bg_lut;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fg_rgb_q <= '0;
      bg_rgb_q <= '0;
    end else begin
      fg_rgb_q <= fg_rgb_d;
      bg_rgb_q <= bg_rgb_d;
    end
  end

  assign fg_rgb_o = fg_rgb_q;
  assign bg_rgb_o = bg_rgb_q;

endmodule

// File: tb/tb_vga_attribute_decoder.sv
// Scoreboard bench for vga_attribute_decoder: stimulus queues the
// expected colours, a monitor compares them after each clock edge.
module tb_vga_attribute_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  attr;
  logic        blink;
  logic [11:0] fg;
  logic [11:0] bg;

  int total;
  int bad;

  typedef struct {
    logic [11:0] fg;
    logic [11:0] bg;
    string       name;
  } exp_t;

  exp_t q[$];

  logic [11:0] pal [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  vga_attribute_decoder dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .en_i     (en),
    .attr_i   (attr),
    .blink_i  (blink),
    .fg_rgb_o (fg),
    .bg_rgb_o (bg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [11:0] af, logic [11:0] ab,
                       logic [11:0] ef, logic [11:0] eb);
    total++;
    if (af !== ef || ab !== eb) begin
      bad++;
      $display("FAIL %s: got fg=%h bg=%h, want fg=%h bg=%h",
               nm, af, ab, ef, eb);
    end
  endtask

  // One clock of stimulus; the monitor checks it after the next edge.
  task automatic step(logic e, logic [7:0] a, logic b,
                      logic [11:0] ef, logic [11:0] eb, string nm);
    exp_t x;
    @(negedge clk);
    en    = e;
    attr  = a;
    blink = b;
    x.fg   = ef;
    x.bg   = eb;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
      q.delete();
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && q.size() != 0) begin
      exp_t x;
      #1;
      x = q.pop_front();
      check(x.name, fg, bg, x.fg, x.bg);
    end
  end

  initial begin
    logic [7:0] a;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    attr  = 8'h00;
    blink = 1'b0;
    #1;
    check("reset_init", fg, bg, 12'h000, 12'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 8'hFF, 1'b0, 12'h000, 12'h000, "idle_no_load");
    step(1'b1, 8'h17, 1'b0, 12'hAAA, 12'h00A, "load_17");
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h4E, 1'b0, 12'hAAA, 12'h00A, "hold_4E");
    step(1'b0, 8'hxx, 1'b1, 12'hAAA, 12'h00A, "hold_x");
    step(1'b1, 8'h06, 1'b0, 12'hA50, 12'h000, "brown_06");

    for (int i = 0; i < 16; i++) begin
      a = {1'b0, i[2:0], i[3:0]};
      step(1'b1, a, 1'b0, pal[i], pal[i[2:0]], "sweep");
    end
    step(1'b1, 8'h70, 1'b0, 12'h000, 12'hAAA, "bg7");
    step(1'b1, 8'h4E, 1'b0, 12'hFF5, 12'hA00, "load_4E");

`ifdef VGA_ATTR_BLINK_EN
    step(1'b1, 8'hF0, 1'b0, 12'h000, 12'hAAA, "bit7_F0");
    step(1'b1, 8'h9F, 1'b0, 12'hFFF, 12'h00A, "blink_off");
    step(1'b1, 8'h9F, 1'b1, 12'h00A, 12'h00A, "blink_on");
    step(1'b1, 8'h1F, 1'b1, 12'hFFF, 12'h00A, "noblink_flag");
    step(1'b0, 8'h1F, 1'b0, 12'hFFF, 12'h00A, "blink_hold");
`else
    step(1'b1, 8'hF0, 1'b0, 12'h000, 12'hFFF, "bit7_F0");
    step(1'b1, 8'h9F, 1'b0, 12'hFFF, 12'h55F, "bright_9F");
    step(1'b1, 8'h9F, 1'b1, 12'hFFF, 12'h55F, "blink_ignored");
    step(1'b1, 8'hC4, 1'b1, 12'hA00, 12'hF55, "bright_C4");
`endif
    drain();

    // Async reset mid-cycle with non-zero outputs.
    @(negedge clk);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", fg, bg, 12'h000, 12'h000);
    @(posedge clk);
    #1;
    check("reset_hold", fg, bg, 12'h000, 12'h000);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 8'h17, 1'b0, 12'h000, 12'h000, "post_rst_idle");
    step(1'b1, 8'h2B, 1'b0, 12'h5FF, 12'h0A0, "post_rst_load");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
